// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
// Holds the BCD digit type, the display idle code, the writer FSM states
// and the default number of display positions.
package calc_pkg;

    typedef logic [3:0] bcd_digit_t;

    // pos/dig value that the display controller treats as "no write this cycle"
    localparam bcd_digit_t IDLE_CODE = 4'hF;

    localparam int NDIG_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        WRITE,
        DONE
    } writer_state_t;

endpackage

// File: rtl/display_writer_if.sv
// Request/digit-write bundle between the calculator and the display writer.
// master: the writer (takes start/value, drives busy/dig/pos/done/ovf).
// slave: the requester and display side (drives start/value, observes the rest).
interface display_writer_if #(
    parameter int WIDTH = 27
);
    import calc_pkg::*;

    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    bcd_digit_t       dig;
    logic [3:0]       pos;
    logic             done;
    logic             ovf;

    modport master (
        input  start, value,
        output busy, dig, pos, done, ovf
    );

    modport slave (
        output start, value,
        input  busy, dig, pos, done, ovf
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
// Ports: din (nibble before correction), dout (corrected nibble).
// Purely combinational, no backpressure.
module bcd_add3
    import calc_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/display_writer.sv
// Converts a binary result to BCD (shift-add-3) and writes NDIG digits, units first.
// Ports: clock, reset (async active-low), bus (master side: start/value in; busy/dig/pos/done/ovf out).
// Latency: start at cycle 0 -> writes cycles WIDTH+1..WIDTH+NDIG -> done next cycle; start ignored while busy.
module display_writer
    import calc_pkg::*;
#(
    parameter int NDIG  = NDIG_DEFAULT,
    parameter int WIDTH = 27
) (
    input  logic             clock,
    input  logic             reset,
    display_writer_if.master bus
);

    localparam logic [WIDTH-1:0] MAXVAL = WIDTH'(10 ** NDIG - 1);
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH + 1);

    writer_state_t    state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    bcd_digit_t       pos_q, pos_d;
    bcd_digit_t       dig_q, dig_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;

    // All nibbles are corrected in parallel before the shift.
    for (genvar i = 0; i < NDIG; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_q[4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

    assign shifted = {adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pos_d   = IDLE_CODE;
        dig_d   = IDLE_CODE;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CONVERT;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    if (bus.value > MAXVAL) begin
                        bin_d = MAXVAL;
                        ovf_d = 1'b1;
                    end else begin
                        bin_d = bus.value;
                        ovf_d = 1'b0;
                    end
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = shifted;
                cnt_d = cnt_q + 1'b1;
                // On the final shift, preload the first write from the shifted result
                // so pos/dig stay registered with no bubble.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = WRITE;
                    pos_d   = 4'd0;
                    dig_d   = shifted[WIDTH +: 4];
                end
            end
            WRITE: begin
                if (pos_q == 4'(NDIG - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    pos_d = pos_q + 4'd1;
                    dig_d = bcd_q[4*(int'(pos_q) + 1) +: 4];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= IDLE_CODE;
            dig_q   <= IDLE_CODE;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dig_q   <= dig_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.pos  = pos_q;
    assign bus.dig  = dig_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_display_writer.sv
// Directed bench for display_writer: per-cycle check of busy/pos/dig/done
// against hand-computed BCD digit words, plus an always-on invariant monitor.
module tb_display_writer;
    import calc_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    display_writer_if #(.WIDTH(27)) bus ();

    display_writer #(.NDIG(8), .WIDTH(27)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Invariants checked every cycle while out of reset.
    always @(negedge clock) begin
        if (reset) begin
            checks++;
            assert (bus.pos === 4'hF || (bus.pos < 4'd8 && bus.dig <= 4'd9)) else begin
                errors++;
                $error("FAIL mon_dig: pos %0h dig %0h", bus.pos, bus.dig);
            end
            checks++;
            assert (bus.busy === 1'b1 || bus.pos === 4'hF) else begin
                errors++;
                $error("FAIL mon_idle_pos: busy %0b pos %0h", bus.busy, bus.pos);
            end
        end
    end

    // One transaction. exp_bcd holds the expected digits, nibble k = position k.
    // x1/x2: cycles in which a stray start (other value) is pulsed; 0 = none.
    // rst_cyc: cycle in which reset is pulled low mid-transaction; 0 = none.
    task automatic run(input string name, input logic [26:0] v, input logic [31:0] exp_bcd,
                       input logic exp_ovf, input int x1, input int x2, input int rst_cyc);
        logic [3:0] ep, ed;
        @(negedge clock);
        bus.start = 1'b1;
        bus.value = v;
        for (int c = 1; c <= 37; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            bus.value = 27'h7FF_FFFF;
            if (c == rst_cyc) begin
                reset = 1'b0;
                #1;
                chk({name, "_rst_pos"},  32'(bus.pos),  32'hF);
                chk({name, "_rst_dig"},  32'(bus.dig),  32'hF);
                chk({name, "_rst_busy"}, 32'(bus.busy), 32'h0);
                chk({name, "_rst_done"}, 32'(bus.done), 32'h0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    chk({name, "_rst_hold_pos"},  32'(bus.pos),  32'hF);
                    chk({name, "_rst_hold_done"}, 32'(bus.done), 32'h0);
                end
                reset = 1'b1;
                return;
            end
            if (c >= 28 && c <= 35) begin
                ep = 4'(c - 28);
                ed = exp_bcd[4*(c-28) +: 4];
            end else begin
                ep = 4'hF;
                ed = 4'hF;
            end
            chk($sformatf("%s_c%0d_pos", name, c),  32'(bus.pos),  32'(ep));
            chk($sformatf("%s_c%0d_dig", name, c),  32'(bus.dig),  32'(ed));
            chk($sformatf("%s_c%0d_done", name, c), 32'(bus.done), 32'(c == 36));
            chk($sformatf("%s_c%0d_busy", name, c), 32'(bus.busy), 32'(c <= 36));
            if (c == 1) chk({name, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
            if (c == x1 || c == x2) begin
                bus.start = 1'b1;
                bus.value = 27'd11111111;
            end
        end
        chk({name, "_ovf_end"}, 32'(bus.ovf), 32'(exp_ovf));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.value = '0;
        #12;
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_ovf",  32'(bus.ovf),  32'h0);
        chk("reset_pos",  32'(bus.pos),  32'hF);
        chk("reset_dig",  32'(bus.dig),  32'hF);
        @(negedge clock);
        reset = 1'b1;

        run("v12345678", 27'd12345678,  32'h12345678, 1'b0, 0, 0, 0);
        run("v0",        27'd0,         32'h00000000, 1'b0, 0, 0, 0);
        run("vmax",      27'd99999999,  32'h99999999, 1'b0, 0, 0, 0);
        run("vsat",      27'd100000000, 32'h99999999, 1'b1, 0, 0, 0);
        run("v5",        27'd5,         32'h00000005, 1'b0, 0, 0, 0);
        // stray starts during CONVERT, during WRITE, and in the DONE cycle
        run("vign",      27'd87654321,  32'h87654321, 1'b0, 10, 30, 0);
        run("vdone_st",  27'd90817263,  32'h90817263, 1'b0, 36, 0, 0);
        run("vrst",      27'd12345678,  32'h12345678, 1'b0, 0, 0, 31);
        run("v42",       27'd42,        32'h00000042, 1'b0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/display_writer.md
Name: display_writer

Overview:
- Producer side of the display digit-write interface (dig/pos pair, one write per clock).
- Accepts a binary result from the calculator datapath and converts it to BCD by shift-add-3 (double dabble).
- Streams the digits into the 8-position display controller, least-significant digit first.
- Drives pos/dig to the idle code when not writing, so the display controller ignores those cycles.

Parameters:
- NDIG, 8, number of display positions written; pos range is 0..NDIG-1.
- WIDTH, 27, width of the binary input value; 2^27 > 99_999_999.
- MAXVAL, 10^NDIG-1 (99_999_999), saturation limit; localparam, derived from NDIG.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to display value; sampled only in IDLE.
- value  in  WIDTH  unsigned binary result, captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- dig  out  4  BCD digit 0..9 during WRITE; 4'hF otherwise.
- pos  out  4  display position 0..NDIG-1 during WRITE; 4'hF otherwise (idle code, no write).
- done  out  1  one-cycle pulse in the cycle after the last digit write.
- ovf  out  1  registered flag: last accepted value exceeded MAXVAL; updated on each accepted start.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; shift register and counters go to 0.
  - Outputs: busy=0, done=0, ovf=0, dig=4'hF, pos=4'hF.
  - Takes effect immediately, including mid-CONVERT or mid-WRITE. Digits already written stay on the display; no further writes are issued.
- IDLE:
  - If start=1, capture value. If value>MAXVAL, load MAXVAL instead and set ovf=1; otherwise ovf=0.
  - Clear the BCD field (4*NDIG bits), bit counter=0, go to CONVERT.
  - busy rises in the cycle after start.
- CONVERT, exactly WIDTH cycles:
  - Each cycle, every BCD nibble >=5 gets +3 (all nibbles in parallel, combinational).
  - Then the concatenated {bcd, bin} register shifts left by 1.
  - After WIDTH shifts, go to WRITE with digit index k=0.
- WRITE, exactly NDIG cycles:
  - Cycle k drives pos=k and dig=bcd nibble k (nibble 0 = units).
  - Leading zeros are written as 0; no blanking.
  - All NDIG positions are always written, so stale digits from an earlier result are overwritten.
  - After k=NDIG-1, go to DONE.
- DONE, 1 cycle: done=1, pos=dig=4'hF; next state IDLE.
- Outputs dig/pos/done are registered (driven from flops, no combinational path from start/value).
- Latency: start at cycle 0 → first write at cycle WIDTH+1 (28) → last write at cycle WIDTH+NDIG (35) → done at cycle 36 → IDLE at cycle 37, when a new start can be accepted.
- start while busy=1 is ignored, not queued. start asserted in the same cycle DONE exits is also ignored.
- value changing after capture has no effect.
- dig is never ≥10 while pos<NDIG. The display controller relies on this.

Decomposition:
- Shared package calc_pkg holds:
  - typedef bcd_digit_t (logic[3:0]).
  - IDLE_CODE = 4'hF.
  - enum writer_state_t {IDLE, CONVERT, WRITE, DONE}.
  - NDIG_DEFAULT = 8.
- One natural sub-module: bcd_add3 (4-bit in/out: adds 3 if ≥5), instantiated NDIG times in a generate loop. The rest is one FSM plus datapath.

Test Plan:
- value=12345678, start pulse → 8 writes (pos,dig) in order (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1); then done pulse at cycle 36; ovf=0.
- value=0 → writes dig=0 at pos 0..7; value=99_999_999 → all dig=9; ovf=0 in both cases.
- value=100_000_000 → ovf=1, all eight writes dig=9. Follow with value=5 → ovf=0, pos0=5, pos1..7=0.
- Second start pulse during CONVERT and during WRITE → ignored: exactly 8 writes and one done; digits match the first value.
- Reset low at cycle 31 (mid-WRITE) → pos=dig=4'hF and busy=0 immediately, no done pulse; after release, a start with value=42 yields a complete write sequence.
- Monitor over all tests: whenever pos<8, dig≤9; pos=4'hF whenever busy=0 or state≠WRITE.
